mccpu_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM for the MCCPU datapath; replaces single-cycle decode.

---
 rtl/mccpu_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mccpu_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mccpu_ctrl.sv
//------------------------------------------------------------------------------
// mccpu_ctrl : multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) for the MCCPU datapath
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mccpu_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic [2:0]         ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic               ALUSrcB,
    output logic [1:0]         NPCOp,
    output logic               GPRSel,
    output logic               WDSel,
    output logic               Retire,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [2:0] c_ALU_NOP  = 3'b000;
    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;
    localparam logic [2:0] c_ALU_AND  = 3'b011;
    localparam logic [2:0] c_ALU_OR   = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b110;
    localparam logic [2:0] c_ALU_SLL  = 3'b111;

    state_t r_state;

    logic       w_legal;
    logic [2:0] w_alu_op;
    logic [1:0] w_src_a;
    logic       w_src_b;
    logic       w_ext;
    logic       w_gpr_rt;
    logic       w_is_j;
    logic       w_is_beq;
    logic       w_is_lw;
    logic       w_is_sw;

    assign w_is_j   = (Op == 6'h02);
    assign w_is_beq = (Op == 6'h04);
    assign w_is_lw  = (Op == 6'h23);
    assign w_is_sw  = (Op == 6'h2B);

    // Instruction decode; anything not listed stays illegal and retires as a NOP.
    always_comb begin
        w_legal  = 1'b0;
        w_alu_op = c_ALU_NOP;
        w_src_a  = 2'b00;
        w_src_b  = 1'b0;
        w_ext    = 1'b0;
        w_gpr_rt = 1'b0;
        case (Op)
            6'h00: begin
                w_legal = 1'b1;
                case (Funct)
                    6'h20, 6'h21: w_alu_op = c_ALU_ADD;
                    6'h22, 6'h23: w_alu_op = c_ALU_SUB;
                    6'h24:        w_alu_op = c_ALU_AND;
                    6'h25:        w_alu_op = c_ALU_OR;
                    6'h2A:        w_alu_op = c_ALU_SLT;
                    6'h2B:        w_alu_op = c_ALU_SLTU;
                    6'h00: begin
                        w_alu_op = c_ALU_SLL;
                        w_src_a  = 2'b01;
                    end
                    default:      w_legal  = 1'b0;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                w_legal  = 1'b1;
                w_alu_op = c_ALU_ADD;
                w_src_b  = 1'b1;
                w_ext    = 1'b1;
                w_gpr_rt = (Op != 6'h2B);
            end
            6'h0D: begin
                w_legal  = 1'b1;
                w_alu_op = c_ALU_OR;
                w_src_b  = 1'b1;
                w_gpr_rt = 1'b1;
            end
            6'h0F: begin
                // ALU passes operand A (the pre-shifted lui immediate) on NOP
                w_legal  = 1'b1;
                w_src_a  = 2'b10;
                w_src_b  = 1'b1;
                w_gpr_rt = 1'b1;
            end
            6'h04: begin
                w_legal  = 1'b1;
                w_alu_op = c_ALU_SUB;
            end
            6'h02:   w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            case (r_state)
                S_IF:  r_state <= MemReady ? S_ID : S_IF;
                S_ID:  r_state <= (w_is_j || !w_legal) ? S_IF : S_EX;
                S_EX: begin
                    if (w_is_lw || w_is_sw)
                        r_state <= S_MEM;
                    else if (w_is_beq || !w_legal)
                        r_state <= S_IF;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (!MemReady)
                        r_state <= S_MEM;
                    else
                        r_state <= w_is_lw ? S_WB : S_IF;
                end
                S_WB:    r_state <= S_IF;
                default: r_state <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = c_ALU_NOP;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 1'b0;
        NPCOp    = 2'b00;
        GPRSel   = 1'b0;
        WDSel    = 1'b0;
        Retire   = 1'b0;
        case (r_state)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_ID: begin
                if (w_is_j) begin
                    PCWrite = 1'b1;
                    NPCOp   = 2'b10;
                end
                Retire = w_is_j || !w_legal;
            end
            S_EX: begin
                ALUOp   = w_alu_op;
                ALUSrcA = w_src_a;
                ALUSrcB = w_src_b;
                EXTOp   = w_ext;
                if (w_is_beq) begin
                    PCWrite = Zero;
                    NPCOp   = 2'b01;
                    Retire  = 1'b1;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = w_is_lw;
                MemWrite = w_is_sw;
                Retire   = w_is_sw && MemReady;
            end
            S_WB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
                GPRSel   = w_gpr_rt;
                WDSel    = w_is_lw;
            end
            default: ;
        endcase
        // Reset overrides every enable whatever state the FSM was caught in.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Retire   = 1'b0;
        end
    end

    assign State = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mccpu_ctrl.sv
//------------------------------------------------------------------------------
// tb_mccpu_ctrl : scoreboard bench for the multi-cycle control FSM
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mccpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, MemReady;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp;
    logic [2:0] ALUOp;
    logic [1:0] ALUSrcA, NPCOp;
    logic       ALUSrcB, GPRSel, WDSel, Retire;
    logic [2:0] State;

    int errors = 0;
    int checks = 0;

    mccpu_ctrl #(.STATE_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .NPCOp(NPCOp), .GPRSel(GPRSel),
        .WDSel(WDSel), .Retire(Retire), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        ready;
        logic        zero;
        logic [20:0] exp;
    } rec_t;

    rec_t sbq[$];

    localparam int CL_ILL = 0, CL_R = 1, CL_I = 2, CL_LW = 3, CL_SW = 4, CL_BEQ = 5, CL_J = 6;

    function automatic logic [20:0] pk(input logic [2:0] st, input logic pcw, input logic irw,
        input logic iord, input logic mr, input logic mw, input logic rw, input logic ext,
        input logic [2:0] aop, input logic [1:0] sa, input logic sbb, input logic [1:0] npc,
        input logic gpr, input logic wd, input logic ret);
        return {st, pcw, irw, iord, mr, mw, rw, ext, aop, sa, sbb, npc, gpr, wd, ret};
    endfunction

    function automatic logic [20:0] observed();
        return {State, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp,
                ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel, Retire};
    endfunction

    // Reference decode table, written from the instruction list
    function automatic void dec(input logic [5:0] op, input logic [5:0] fn, output int cls,
        output logic [2:0] aop, output logic [1:0] sa, output logic sbb,
        output logic ext, output logic gpr);
        cls = CL_ILL; aop = 3'd0; sa = 2'd0; sbb = 1'b0; ext = 1'b0; gpr = 1'b0;
        if (op == 6'h00) begin
            cls = CL_R;
            if (fn == 6'h20 || fn == 6'h21) aop = 3'd1;
            else if (fn == 6'h22 || fn == 6'h23) aop = 3'd2;
            else if (fn == 6'h24) aop = 3'd3;
            else if (fn == 6'h25) aop = 3'd4;
            else if (fn == 6'h2A) aop = 3'd5;
            else if (fn == 6'h2B) aop = 3'd6;
            else if (fn == 6'h00) begin aop = 3'd7; sa = 2'b01; end
            else cls = CL_ILL;
        end else if (op == 6'h08) begin cls = CL_I;  aop = 3'd1; sbb = 1; ext = 1; gpr = 1; end
        else if (op == 6'h0D) begin cls = CL_I;  aop = 3'd4; sbb = 1; gpr = 1; end
        else if (op == 6'h0F) begin cls = CL_I;  sa = 2'b10; sbb = 1; gpr = 1; end
        else if (op == 6'h23) begin cls = CL_LW; aop = 3'd1; sbb = 1; ext = 1; gpr = 1; end
        else if (op == 6'h2B) begin cls = CL_SW; aop = 3'd1; sbb = 1; ext = 1; end
        else if (op == 6'h04) begin cls = CL_BEQ; aop = 3'd2; end
        else if (op == 6'h02) cls = CL_J;
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic z, input logic [20:0] e);
        rec_t r;
        r.op = op; r.funct = fn; r.ready = rdy; r.zero = z; r.exp = e;
        sbq.push_back(r);
    endtask

    // Expected per-cycle sequence for one instruction with given IF/MEM wait counts
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int wif, input int wmem);
        int cls; logic [2:0] aop; logic [1:0] sa; logic sbb, ext, gpr;
        logic lw, sw;
        dec(op, fn, cls, aop, sa, sbb, ext, gpr);
        lw = (cls == CL_LW);
        sw = (cls == CL_SW);
        for (int i = 0; i < wif; i++)
            push(op, fn, 0, z, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(op, fn, 1, z, pk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (cls == CL_J) begin
            push(op, fn, 1, z, pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 1));
            return;
        end
        if (cls == CL_ILL) begin
            push(op, fn, 1, z, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        push(op, fn, 1, z, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (cls == CL_BEQ) begin
            push(op, fn, 1, z, pk(2, z, 0, 0, 0, 0, 0, 0, aop, sa, sbb, 2'b01, 0, 0, 1));
            return;
        end
        push(op, fn, 1, z, pk(2, 0, 0, 0, 0, 0, 0, ext, aop, sa, sbb, 0, 0, 0, 0));
        if (lw || sw) begin
            for (int i = 0; i < wmem; i++)
                push(op, fn, 0, z, pk(3, 0, 0, 1, lw, sw, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            push(op, fn, 1, z, pk(3, 0, 0, 1, lw, sw, 0, 0, 0, 0, 0, 0, 0, 0, sw));
            if (sw) return;
        end
        push(op, fn, 1, z, pk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, gpr, lw, 1));
    endtask

    // Entered and left just after a falling edge; one record per clock.
    task automatic run_sb(input string name, input int n_instr);
        rec_t r;
        int   retired = 0;
        int   cyc = 0;
        logic [20:0] obs;
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            Op = r.op; Funct = r.funct; MemReady = r.ready; Zero = r.zero;
            #2;
            obs = observed();
            checks++;
            if (obs !== r.exp) begin
                errors++;
                $display("FAIL %s cycle %0d outputs: got %06h expected %06h", name, cyc, obs, r.exp);
            end
            if (Retire === 1'b1) retired++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (retired !== n_instr) begin
            errors++;
            $display("FAIL %s retire count: got %0d expected %0d", name, retired, n_instr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
        @(negedge clk); @(negedge clk);
        #2;
        checks++;
        if (State !== 3'd0 || {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Retire} !== 6'b0) begin
            errors++;
            $display("FAIL reset: got state=%0d enables=%06b expected state=0 enables=000000",
                     State, {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Retire});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_mem();
        Op = 6'h2B; Funct = 6'h00; MemReady = 1'b1;
        @(negedge clk); @(negedge clk);
        MemReady = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if (State !== 3'd3 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem_entry: got state=%0d MemWrite=%b expected state=3 MemWrite=1", State, MemWrite);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || State !== 3'd3) begin
            errors++;
            $display("FAIL rst_in_mem: got MemWrite=%b state=%0d expected MemWrite=0 state=3", MemWrite, State);
        end
        @(negedge clk);
        #2;
        checks++;
        if (State !== 3'd0 || MemWrite !== 1'b0 || MemRead !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_edge: got state=%0d MemWrite=%b MemRead=%b expected 0 0 0",
                     State, MemWrite, MemRead);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        push_instr(6'h00, 6'h20, 0, 0, 0);
        run_sb("add", 1);
    endtask

    task automatic test_lw_wait();
        push_instr(6'h23, 6'h00, 0, 0, 3);
        run_sb("lw_wait", 1);
    endtask

    task automatic test_beq();
        push_instr(6'h04, 6'h00, 1, 0, 0);
        push_instr(6'h04, 6'h00, 0, 0, 0);
        run_sb("beq", 2);
    endtask

    task automatic test_j();
        push_instr(6'h02, 6'h00, 0, 0, 0);
        run_sb("j", 1);
    endtask

    task automatic test_illegal_sll();
        push_instr(6'h3F, 6'h00, 0, 0, 0);
        push_instr(6'h00, 6'h3F, 0, 0, 0);
        push_instr(6'h00, 6'h00, 0, 0, 0);
        run_sb("illegal_sll", 3);
    endtask

    task automatic test_back_to_back();
        push_instr(6'h00, 6'h22, 0, 0, 0);
        push_instr(6'h00, 6'h21, 0, 1, 0);
        push_instr(6'h00, 6'h23, 0, 0, 0);
        push_instr(6'h00, 6'h24, 0, 0, 0);
        push_instr(6'h00, 6'h25, 0, 0, 0);
        push_instr(6'h00, 6'h2A, 0, 2, 0);
        push_instr(6'h00, 6'h2B, 0, 0, 0);
        push_instr(6'h08, 6'h11, 0, 0, 0);
        push_instr(6'h0D, 6'h22, 0, 0, 0);
        push_instr(6'h0F, 6'h00, 0, 0, 0);
        push_instr(6'h2B, 6'h04, 0, 1, 2);
        push_instr(6'h23, 6'h08, 0, 0, 0);
        push_instr(6'h04, 6'h00, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            push_instr(6'h00, 6'h20, 0, $urandom_range(0, 2), 0);
        run_sb("back_to_back", 17);
    endtask

    initial begin
        test_reset();
        test_rst_mid_mem();
        test_add();
        test_lw_wait();
        test_beq();
        test_j();
        test_illegal_sll();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
